// File: rtl/reg_xfer_sequencer.sv
// Register-transfer / increment-decrement sequencer for the 6502 A/X/Y/SP set.
// One op per handshake: DRIVE selects the bus source, WRITE strobes the destination, FLAGS reports N/Z.
module reg_xfer_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] a_val,
    input  logic [DATA_WIDTH-1:0] x_val,
    input  logic [DATA_WIDTH-1:0] y_val,
    input  logic [DATA_WIDTH-1:0] sp_val,
    output logic [1:0]            bus_sel,
    output logic [3:0]            load_en,
    output logic [3:0]            inc_en,
    output logic [3:0]            dec_en,
    output logic                  flag_we,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  done,
    output logic                  err
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_TAX = 4'h1;
    localparam logic [3:0] OP_TAY = 4'h2;
    localparam logic [3:0] OP_TXA = 4'h3;
    localparam logic [3:0] OP_TYA = 4'h4;
    localparam logic [3:0] OP_TSX = 4'h5;
    localparam logic [3:0] OP_TXS = 4'h6;
    localparam logic [3:0] OP_INX = 4'h7;
    localparam logic [3:0] OP_INY = 4'h8;
    localparam logic [3:0] OP_DEX = 4'h9;
    localparam logic [3:0] OP_DEY = 4'hA;

    localparam logic [1:0] R_A  = 2'd0;
    localparam logic [1:0] R_X  = 2'd1;
    localparam logic [1:0] R_Y  = 2'd2;
    localparam logic [1:0] R_SP = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WRITE = 2'd2,
        FLAGS = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [3:0]            op_q;
    logic                  err_q;
    logic                  accept;
    logic                  trap;
    logic [1:0]            src;
    logic [1:0]            dst;
    logic                  is_xfer;
    logic                  is_inc;
    logic                  is_dec;
    logic                  sets_flags;
    logic [3:0]            dst_oh;
    logic [DATA_WIDTH-1:0] dst_val;

    assign cmd_ready = (state == IDLE) || (state == FLAGS);
    assign accept    = cmd_valid && ((state == IDLE) || (state == FLAGS));
    assign trap      = ILLEGAL_TRAP && (cmd_op > OP_DEY);
    assign dst_oh    = 4'(1) << dst;
    assign err       = err_q;

    // Undefined codes never reach op_q when trapping; otherwise they decode like NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= OP_NOP;
            err_q <= 1'b0;
        end else begin
            if (accept && !trap) begin
                op_q <= cmd_op;
            end
            err_q <= accept && trap;
        end
    end

    // Source/destination and action decode of the latched op.
    always_comb begin
        src        = R_A;
        dst        = R_A;
        is_xfer    = 1'b0;
        is_inc     = 1'b0;
        is_dec     = 1'b0;
        sets_flags = 1'b0;
        case (op_q)
            OP_TAX: begin src = R_A;  dst = R_X;  is_xfer = 1'b1; sets_flags = 1'b1; end
            OP_TAY: begin src = R_A;  dst = R_Y;  is_xfer = 1'b1; sets_flags = 1'b1; end
            OP_TXA: begin src = R_X;  dst = R_A;  is_xfer = 1'b1; sets_flags = 1'b1; end
            OP_TYA: begin src = R_Y;  dst = R_A;  is_xfer = 1'b1; sets_flags = 1'b1; end
            OP_TSX: begin src = R_SP; dst = R_X;  is_xfer = 1'b1; sets_flags = 1'b1; end
            OP_TXS: begin src = R_X;  dst = R_SP; is_xfer = 1'b1; end
            OP_INX: begin src = R_X;  dst = R_X;  is_inc  = 1'b1; sets_flags = 1'b1; end
            OP_INY: begin src = R_Y;  dst = R_Y;  is_inc  = 1'b1; sets_flags = 1'b1; end
            OP_DEX: begin src = R_X;  dst = R_X;  is_dec  = 1'b1; sets_flags = 1'b1; end
            OP_DEY: begin src = R_Y;  dst = R_Y;  is_dec  = 1'b1; sets_flags = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        case (dst)
            R_A:     dst_val = a_val;
            R_X:     dst_val = x_val;
            R_Y:     dst_val = y_val;
            default: dst_val = sp_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus_sel    = R_A;
        load_en    = 4'b0000;
        inc_en     = 4'b0000;
        dec_en     = 4'b0000;
        flag_we    = 1'b0;
        flag_n     = 1'b0;
        flag_z     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = trap ? IDLE : DRIVE;
                end
            end
            DRIVE: begin
                bus_sel    = src;
                state_next = WRITE;
            end
            WRITE: begin
                bus_sel    = src;
                load_en    = is_xfer ? dst_oh : 4'b0000;
                inc_en     = is_inc  ? dst_oh : 4'b0000;
                dec_en     = is_dec  ? dst_oh : 4'b0000;
                state_next = FLAGS;
            end
            FLAGS: begin
                done       = 1'b1;
                flag_we    = sets_flags;
                flag_n     = dst_val[DATA_WIDTH-1];
                flag_z     = (dst_val == '0);
                state_next = (accept && !trap) ? DRIVE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Directed bench for reg_xfer_sequencer: a trapping and a non-trapping instance,
// a small register-file model driven by the strobes, and a scoreboard checked on each done.
module tb_reg_xfer_sequencer;

    typedef struct {
        logic fwe;
        logic n;
        logic z;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_valid1;
    logic [3:0] cmd_op, cmd_op1;
    logic       cmd_ready, cmd_ready1;
    logic [1:0] bus_sel, bus_sel1;
    logic [3:0] load_en, inc_en, dec_en, load_en1, inc_en1, dec_en1;
    logic       flag_we, flag_n, flag_z, done, err;
    logic       flag_we1, flag_n1, flag_z1, done1, err1;

    logic [7:0] regs [4];
    logic       pre_en;
    logic [1:0] pre_idx;
    logic [7:0] pre_val;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_xfer_sequencer #(.DATA_WIDTH(8), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .a_val(regs[0]), .x_val(regs[1]), .y_val(regs[2]), .sp_val(regs[3]),
        .bus_sel(bus_sel), .load_en(load_en), .inc_en(inc_en), .dec_en(dec_en),
        .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z), .done(done), .err(err)
    );

    reg_xfer_sequencer #(.DATA_WIDTH(8), .ILLEGAL_TRAP(1'b0)) dut_nt (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1),
        .a_val(regs[0]), .x_val(regs[1]), .y_val(regs[2]), .sp_val(regs[3]),
        .bus_sel(bus_sel1), .load_en(load_en1), .inc_en(inc_en1), .dec_en(dec_en1),
        .flag_we(flag_we1), .flag_n(flag_n1), .flag_z(flag_z1), .done(done1), .err(err1)
    );

    // Register-file model: latency-1 load/inc/dec from the trapping instance's strobes.
    always @(posedge clk) begin
        if (pre_en) begin
            regs[pre_idx] <= pre_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load_en[i])     regs[i] <= regs[bus_sel];
                else if (inc_en[i]) regs[i] <= regs[i] + 8'd1;
                else if (dec_en[i]) regs[i] <= regs[i] - 8'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done on the trapping instance pops one expected flag result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_flag_we", flag_we, e.fwe);
                if (e.fwe) begin
                    chk("sb_flag_n", flag_n, e.n);
                    chk("sb_flag_z", flag_z, e.z);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input logic [1:0] idx, input logic [7:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [3:0] op, input logic [1:0] bsel,
                          input logic [3:0] ld, input logic [3:0] inc, input logic [3:0] dec,
                          input logic fwe, input logic n, input logic z);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        chk({nm, "_ready"}, cmd_ready, 1'b1);
        e.fwe = fwe; e.n = n; e.z = z;
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        chk({nm, "_drive_bus"}, bus_sel, bsel);
        chk({nm, "_drive_strobes"}, {load_en, inc_en, dec_en}, 12'h000);
        chk({nm, "_drive_ready"}, cmd_ready, 1'b0);
        tick();
        chk({nm, "_write_bus"}, bus_sel, bsel);
        chk({nm, "_write_strobes"}, {load_en, inc_en, dec_en}, {ld, inc, dec});
        tick();
        chk({nm, "_flags_done"}, done, 1'b1);
        chk({nm, "_flags_ready"}, cmd_ready, 1'b1);
        chk({nm, "_flags_strobes"}, {load_en, inc_en, dec_en}, 12'h000);
        tick();
        chk({nm, "_idle_done"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_valid1 = 1'b0; cmd_op1 = 4'h0;
        pre_en = 1'b0; pre_idx = 2'd0; pre_val = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_outs", {load_en, inc_en, dec_en, flag_we, done, err}, 15'h0000);
        chk("rst_nt_outs", {cmd_ready1, load_en1, inc_en1, dec_en1, flag_we1, done1, err1}, 16'h8000);
        for (int i = 0; i < 4; i++) set_reg(2'(i), 8'h00);

        set_reg(2'd0, 8'h80);
        run_op("tax", 4'h1, 2'd0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
        chk("tax_x_value", regs[1], 8'h80);

        set_reg(2'd1, 8'hFF);
        run_op("inx_wrap", 4'h7, 2'd1, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1);

        set_reg(2'd2, 8'h00);
        run_op("dey_wrap", 4'hA, 2'd2, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0);

        set_reg(2'd1, 8'h42);
        run_op("txs", 4'h6, 2'd1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("txs_sp_value", regs[3], 8'h42);

        set_reg(2'd3, 8'h00);
        run_op("tsx_zero", 4'h5, 2'd3, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        run_op("tya", 4'h4, 2'd2, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
        run_op("nop", 4'h0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        set_reg(2'd2, 8'h7F);
        run_op("iny", 4'h8, 2'd2, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
        set_reg(2'd1, 8'h01);
        run_op("dex", 4'h9, 2'd1, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1);

        // Back-to-back: TAY held while busy, accepted in TAX's FLAGS cycle.
        set_reg(2'd0, 8'h05);
        cmd_valid = 1'b1; cmd_op = 4'h1;
        sb.push_back('{fwe: 1'b1, n: 1'b0, z: 1'b0});
        tick();
        cmd_op = 4'h2;
        chk("b2b_ready_busy", cmd_ready, 1'b0);
        tick();
        chk("b2b_write_tax", load_en, 4'b0010);
        tick();
        chk("b2b_done1", done, 1'b1);
        chk("b2b_ready_flags", cmd_ready, 1'b1);
        sb.push_back('{fwe: 1'b1, n: 1'b0, z: 1'b0});
        tick();
        cmd_valid = 1'b0;
        chk("b2b_tay_drive", {done, bus_sel, load_en}, {1'b0, 2'd0, 4'b0000});
        tick();
        chk("b2b_tay_write", {done, load_en}, {1'b0, 4'b0100});
        tick();
        chk("b2b_done2", done, 1'b1);
        tick();
        chk("b2b_idle", {done, cmd_ready}, 2'b01);
        chk("b2b_y_value", regs[2], 8'h05);

        // Reset held for two cycles while an op is in WRITE: op abandoned.
        cmd_valid = 1'b1; cmd_op = 4'h2;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst_mid_write", load_en, 4'b0100);
        reset = 1'b1;
        tick();
        chk("rst_mid_done", {done, flag_we}, 2'b00);
        tick();
        reset = 1'b0;
        chk("rst_mid_after", {cmd_ready, done, flag_we, load_en, inc_en, dec_en}, 15'h4000);
        tick();
        chk("rst_mid_after2", {cmd_ready, done, flag_we}, 3'b100);

        // Undefined op, trapping instance.
        cmd_valid = 1'b1; cmd_op = 4'hC;
        tick();
        cmd_valid = 1'b0;
        chk("trap_err", err, 1'b1);
        chk("trap_ready", cmd_ready, 1'b1);
        chk("trap_quiet", {done, load_en, inc_en, dec_en}, 13'h0000);
        tick();
        chk("trap_err_pulse", {err, done, load_en, inc_en, dec_en}, 14'h0000);
        tick();
        chk("trap_no_done", done, 1'b0);

        // Undefined op, non-trapping instance: behaves as NOP.
        cmd_valid1 = 1'b1; cmd_op1 = 4'hC;
        chk("nt_ready", cmd_ready1, 1'b1);
        tick();
        cmd_valid1 = 1'b0;
        chk("nt_t1", {err1, done1, load_en1, inc_en1, dec_en1, cmd_ready1}, 15'h0000);
        tick();
        chk("nt_t2", {err1, done1, load_en1, inc_en1, dec_en1}, 14'h0000);
        tick();
        chk("nt_t3_done", {done1, flag_we1, err1}, 3'b100);
        tick();
        chk("nt_t4_idle", {done1, cmd_ready1}, 2'b01);

        tick();
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
